q_sched: RTL
============

# q_sched

Quantization scheduler for the JPEG accelerator. Once per 8x8 block it walks the 64 DCT coefficients in zigzag order. For each coefficient it fetches the matching reciprocal from the luma or chroma quantization table. It rounds and saturates the scaled product, then streams the 64 quantized values to the entropy coder over a valid/ready interface. It sits between the DCT result buffer, the Q-table RAM and the Huffman/RLE stage.

## Interface
- `NCOEF`, 64: coefficients per block; fixed, not to be overridden.
- `OUT_MAX`, 2047: saturation limit on output magnitude.
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start one block; sampled only in IDLE.
- `table_sel_i` in 1: 0 = luma, 1 = chroma; latched with `start_i`.
- `busy_o` out 1: high in RUN and DRAIN.
- `done_o` out 1: one-cycle pulse after the last output is accepted.
- `src_rd_o` out 1: coefficient RAM read enable. The RAM holds its output register when this is low.
- `src_addr_o` out 6: raster address of the coefficient.
- `src_data_i` in 16: signed coefficient, valid the cycle after `src_rd_o`.
- `qt_addr_o` out 7: {`table_sel`, raster address}. Read whenever `src_rd_o` is high.
- `qt_data_i` in 16: unsigned reciprocal r = round(2^15/Q), valid the cycle after the read.
- `out_valid_o` out 1: quantized value available.
- `out_ready_i` in 1: consumer accepts; transfer happens when both are high at a rising edge.
- `out_data_o` out 12: signed quantized coefficient.
- `out_idx_o` out 6: zigzag index 0..63.

## Operation
- FSM states:
  - IDLE: `start_i` → RUN; latch `table_sel_i`; clear issue and output counters.
  - RUN: issue reads for zigzag positions 0..63 in order; after issuing index 63 → DRAIN.
  - DRAIN: wait until output index 63 is transferred → DONE.
  - DONE: `done_o`=1 for one cycle → IDLE.
- `start_i` outside IDLE is ignored, including in DONE.
- Define advance = !`out_valid_o` || `out_ready_i`.
- `src_rd_o` = RUN && advance. Addresses: `src_addr_o` = ZZ2RASTER[issue_cnt]; `qt_addr_o` = {sel, same address}.
- Stage-1 valid bit tracks the read issued in the previous cycle. When advance is high and stage-1 is valid, the output register loads the quantized value and `out_idx_o`, and `out_valid_o` is set.
- A transfer with no new load clears `out_valid_o`.
- Arithmetic, sign-magnitude rounding (half away from zero):
  - m = |x|, 16-bit unsigned; x = -32768 gives m = 32768.
  - p = m*r + 2^14, 32-bit unsigned; cannot overflow.
  - q = p >> 15, then min(q, `OUT_MAX`).
  - Result is -q if x < 0, else q. A zero result is always +0.
- During a stall, the output register, stage-1 valid bit and counters all hold. No read is issued.
- Reset while active: all state returns to IDLE immediately, and the partial block is discarded.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `src_rd_o`=0, `src_addr_o`=0, `qt_addr_o`=0, `out_valid_o`=0, `out_data_o`=0, `out_idx_o`=0.
- With `start_i` in cycle 0:
  - Cycle 1: first read (zigzag 0, raster 0).
  - Cycle 3: first `out_valid_o`.
- With `out_ready_i` constantly high:
  - One output per cycle, indices 0..63 in cycles 3..66.
  - `busy_o` is high in cycles 1..66.
  - `done_o` pulses in cycle 67.
  - A `start_i` in cycle 68 is accepted.
- Throughput is 1 coefficient/cycle. Each stall cycle adds exactly one cycle to the block, with no loss or duplication.
- `out_data_o` and `out_idx_o` are stable while `out_valid_o` && !`out_ready_i`.

## Structure
- Package `jpeg_q_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - ZZ2RASTER 64-entry constant array;
  - `OUT_MAX`;
  - width constants (coefficient 16, reciprocal 16, output 12).
- Sub-module `q_round`: combinational quantizer (x, r → 12-bit result) implementing the arithmetic above. `q_sched` instantiates it between stage 1 and the output register.

## Test plan
- Q=16, r=2048, luma, coefficients x = 100, -100, 24, -24 at zigzag 0..3 → outputs 6, -6, 2, -2 with `out_idx_o` 0..3.
- Saturation: r=32768 (Q=1), x = 32767 and -32768 → 2047 and -2047; x=0 → 0.
- Ordering: RAM holds value = raster address and r=32768 → output k equals ZZ2RASTER[k]; check k=2 → 8 and k=63 → 63. With `table_sel_i`=1, every `qt_addr_o`[6] is 1.
- Backpressure: `out_ready_i` low for cycles 10..14 and every odd cycle thereafter → all 64 values in order, outputs stable while stalled, `done_o` pulse once.
- Start ignored: `start_i` pulsed in cycles 5 and 67 → single block, no restart; start in cycle 68 begins a new block.
- Reset mid-block: `rstn_i` low at cycle 30 → all outputs at reset values immediately; the next start yields index 0 first.

Source files
------------

// File: rtl/jpeg_q_pkg.sv
// Shared constants, state encoding and zigzag scan table for the JPEG quantizer.
package jpeg_q_pkg;
    localparam int NCOEF   = 64;
    localparam int IDX_W   = 6;
    localparam int COEF_W  = 16;
    localparam int RECIP_W = 16;
    localparam int OUT_W   = 12;
    localparam int OUT_MAX = 2047;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Zigzag position -> raster address within the 8x8 block.
    localparam logic [IDX_W-1:0] ZZ2RASTER [NCOEF] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };
endpackage

// File: rtl/q_round.sv
// Combinational quantizer: scales |x| by a Q15 reciprocal, rounds half away
// from zero, saturates the magnitude and restores the sign.
module q_round
    import jpeg_q_pkg::*;
#(
    parameter int OMAX = jpeg_q_pkg::OUT_MAX
) (
    input  logic signed [COEF_W-1:0]  x_i,
    input  logic        [RECIP_W-1:0] r_i,
    output logic signed [OUT_W-1:0]   q_o
);
    logic                 neg;
    logic [COEF_W-1:0]    mag;
    logic [16:0]          qfull;
    logic [OUT_W-2:0]     qsat;
    logic signed [OUT_W-1:0] qpos;

    assign neg = x_i[COEF_W-1];
    // -32768 wraps back to 0x8000, which read unsigned is the wanted 32768.
    assign mag = neg ? COEF_W'(-x_i) : COEF_W'(x_i);

    assign qfull = 17'((32'(mag) * 32'(r_i) + 32'd16384) >> 15);
    assign qsat  = (qfull > 17'(OMAX)) ? (OUT_W-1)'(OMAX) : qfull[OUT_W-2:0];
    assign qpos  = $signed({1'b0, qsat});

    // Negating zero yields zero, so a zero result is always +0.
    assign q_o = neg ? -qpos : qpos;
endmodule

// File: rtl/q_sched.sv
// Block quantization scheduler: issues zigzag-ordered coefficient/reciprocal
// reads, quantizes the returned pair and streams results over valid/ready.
module q_sched #(
    parameter int NCOEF   = 64,
    parameter int OUT_MAX = 2047
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        table_sel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        src_rd_o,
    output logic [5:0]  src_addr_o,
    input  logic [15:0] src_data_i,
    output logic [6:0]  qt_addr_o,
    input  logic [15:0] qt_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [11:0] out_data_o,
    output logic [5:0]  out_idx_o
);
    import jpeg_q_pkg::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCOEF - 1);

    state_e state_q, state_d;
    logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
    logic             sel_q, sel_d;

    logic             s1_vld_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic             out_vld_q;
    logic [OUT_W-1:0] out_data_q;
    logic [IDX_W-1:0] out_idx_q;

    logic             advance;
    logic             xfer;
    logic             rd;
    logic signed [OUT_W-1:0] q_val;

    // The whole pipeline moves only when the output slot is free or draining.
    assign advance = !out_vld_q || out_ready_i;
    assign xfer    = out_vld_q && out_ready_i;
    assign rd      = (state_q == S_RUN) && advance;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        sel_d       = sel_q;
        if (xfer) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_RUN;
                    sel_d       = table_sel_i;
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (rd) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && (out_cnt_q == LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            sel_q       <= sel_d;
        end
    end

    q_round #(
        .OMAX (OUT_MAX)
    ) u_round (
        .x_i (src_data_i),
        .r_i (qt_data_i),
        .q_o (q_val)
    );

    // Stage 1 is the RAM read latency; its data is held by the RAM during stalls.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else if (advance) begin
            s1_vld_q <= rd;
            if (rd) begin
                s1_idx_q <= issue_cnt_q;
            end
            if (s1_vld_q) begin
                out_vld_q  <= 1'b1;
                out_data_q <= q_val;
                out_idx_q  <= s1_idx_q;
            end else begin
                out_vld_q  <= 1'b0;
            end
        end
    end

    assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_DONE);
    assign src_rd_o    = rd;
    assign src_addr_o  = ZZ2RASTER[issue_cnt_q];
    assign qt_addr_o   = {sel_q, src_addr_o};
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
endmodule
